// File: rtl/alu_operand_stage.sv
// Operand stage between ID and EX: selects ALU operands, forwards from EX/MEM
// and MEM/WB, waits on pending loads and registers the operand pair for EX.
module alu_operand_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [1:0]             src_sel,
  input  logic [REG_AW-1:0]      rs1_addr,
  input  logic [REG_AW-1:0]      rs2_addr,
  input  logic [DATA_W-1:0]      reg1_rdata,
  input  logic [DATA_W-1:0]      reg2_rdata,
  input  logic [DATA_W-1:0]      imm,
  input  logic [DATA_W-1:0]      curr_pc,
  input  logic                   exm_wr_en,
  input  logic [REG_AW-1:0]      exm_rd,
  input  logic [DATA_W-1:0]      exm_alu_res,
  input  logic [1:0]             exm_access,
  input  logic                   exm_sign_ext,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_rvalid,
  input  logic                   wb_wr_en,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [DATA_W-1:0]      alu_src1,
  output logic [DATA_W-1:0]      alu_src2,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_REG     = 2'b00;
  localparam logic [1:0] SEL_IMM     = 2'b01;
  localparam logic [1:0] SEL_FOUR_PC = 2'b10;
  localparam logic [1:0] ACC_NONE    = 2'b00;
  localparam logic [1:0] ACC_BYTE    = 2'b01;
  localparam logic [1:0] ACC_HALF    = 2'b10;

  logic              use1, use2;
  logic              exm_hit1, exm_hit2, wb_hit1, wb_hit2;
  logic              exm_is_load, stall, capture;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [DATA_W-1:0] load_data, exm_fwd, fwd1, fwd2, next_src1, next_src2;

  assign use1 = (src_sel == SEL_REG) || (src_sel == SEL_IMM);
  assign use2 = (src_sel == SEL_REG);

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  assign exm_hit1 = exm_wr_en && (exm_rd == rs1_addr) && (rs1_addr != '0);
  assign exm_hit2 = exm_wr_en && (exm_rd == rs2_addr) && (rs2_addr != '0);
  assign wb_hit1  = wb_wr_en && (wb_rd == rs1_addr) && (rs1_addr != '0);
  assign wb_hit2  = wb_wr_en && (wb_rd == rs2_addr) && (rs2_addr != '0);

  assign exm_is_load = (exm_access != ACC_NONE);

  always_comb begin
    load_byte = mem_rdata[7:0];
    case (exm_alu_res[1:0])
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      2'd3:    load_byte = mem_rdata[31:24];
      default: load_byte = mem_rdata[7:0];
    endcase
    load_half = exm_alu_res[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (exm_access)
      ACC_BYTE: load_data = {{(DATA_W-8){exm_sign_ext & load_byte[7]}}, load_byte};
      ACC_HALF: load_data = {{(DATA_W-16){exm_sign_ext & load_half[15]}}, load_half};
      default:  load_data = mem_rdata;
    endcase
  end

  assign exm_fwd = exm_is_load ? load_data : exm_alu_res;
  assign fwd1 = exm_hit1 ? exm_fwd : (wb_hit1 ? wb_data : reg1_rdata);
  assign fwd2 = exm_hit2 ? exm_fwd : (wb_hit2 ? wb_data : reg2_rdata);

  always_comb begin
    next_src1 = imm;
    next_src2 = curr_pc;
    case (src_sel)
      SEL_REG: begin
        next_src1 = fwd1;
        next_src2 = fwd2;
      end
      SEL_IMM: begin
        next_src1 = fwd1;
        next_src2 = imm;
      end
      SEL_FOUR_PC: begin
        next_src1 = DATA_W'(4);
        next_src2 = curr_pc;
      end
      default: begin
        next_src1 = imm;
        next_src2 = curr_pc;
      end
    endcase
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. ex_valid with its operands holds until ex_ready; flush drops the held
  // set and blocks any capture in the same cycle.
  assign stall    = id_valid && exm_is_load && !mem_rvalid &&
                    ((use1 && exm_hit1) || (use2 && exm_hit2));
  assign id_ready = !stall && (!ex_valid || ex_ready);
  assign capture  = id_valid && id_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      alu_src1  <= '0;
      alu_src2  <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush)         ex_valid <= 1'b0;
      else if (capture)  ex_valid <= 1'b1;
      else if (ex_ready) ex_valid <= 1'b0;
      if (capture) begin
        alu_src1 <= next_src1;
        alu_src2 <= next_src2;
      end
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus random traffic, checked
// by a behavioural operand/handshake model and an expected-operand queue.
module tb_alu_operand_stage;

  logic        clk, rst_n, flush, id_valid;
  logic [1:0]  src_sel;
  logic [4:0]  rs1_addr, rs2_addr, exm_rd, wb_rd;
  logic [31:0] reg1_rdata, reg2_rdata, imm, curr_pc, exm_alu_res, mem_rdata, wb_data;
  logic        exm_wr_en, exm_sign_ext, mem_rvalid, wb_wr_en, ex_ready;
  logic [1:0]  exm_access;

  logic        id_ready, ex_valid;
  logic [31:0] alu_src1, alu_src2;
  logic [15:0] stall_cnt;
  logic        s_id_ready, s_ex_valid;
  logic [31:0] s_src1, s_src2;
  logic [1:0]  s_stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  bit  m_valid = 0;
  int  m_cnt   = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .src_sel(src_sel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .reg1_rdata(reg1_rdata), .reg2_rdata(reg2_rdata), .imm(imm), .curr_pc(curr_pc),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_alu_res(exm_alu_res),
    .exm_access(exm_access), .exm_sign_ext(exm_sign_ext), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .stall_cnt(stall_cnt)
  );

  alu_operand_stage #(.STALL_CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(s_id_ready),
    .src_sel(src_sel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .reg1_rdata(reg1_rdata), .reg2_rdata(reg2_rdata), .imm(imm), .curr_pc(curr_pc),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_alu_res(exm_alu_res),
    .exm_access(exm_access), .exm_sign_ext(exm_sign_ext), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(s_ex_valid), .ex_ready(ex_ready), .alu_src1(s_src1), .alu_src2(s_src2),
    .stall_cnt(s_stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [31:0] m_load();
    logic [31:0] v;
    case (exm_access)
      2'd1: begin
        v = (mem_rdata >> (8 * exm_alu_res[1:0])) & 32'hFF;
        if (exm_sign_ext && v >= 128) v = v - 256;
      end
      2'd2: begin
        v = (mem_rdata >> (16 * exm_alu_res[1])) & 32'hFFFF;
        if (exm_sign_ext && v >= 32768) v = v - 65536;
      end
      default: v = mem_rdata;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs != 0 && exm_wr_en && exm_rd == rs) return (exm_access == 0) ? exm_alu_res : m_load();
    if (rs != 0 && wb_wr_en && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  function automatic logic [63:0] m_ops();
    case (src_sel)
      2'd0:    return {m_fwd(rs1_addr, reg1_rdata), m_fwd(rs2_addr, reg2_rdata)};
      2'd1:    return {m_fwd(rs1_addr, reg1_rdata), imm};
      2'd2:    return {32'd4, curr_pc};
      default: return {imm, curr_pc};
    endcase
  endfunction

  function automatic bit m_waits(input logic [4:0] rs);
    return rs != 0 && exm_wr_en && exm_rd == rs && exm_access != 0 && !mem_rvalid;
  endfunction

  function automatic bit m_stall();
    if (!id_valid) return 1'b0;
    case (src_sel)
      2'd0:    return m_waits(rs1_addr) || m_waits(rs2_addr);
      2'd1:    return m_waits(rs1_addr);
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge rst_n) begin
    exp_q.delete();
    m_valid = 0;
    m_cnt   = 0;
  end

  // scoreboard / monitor: sampled mid-cycle, model advanced for the next edge
  always @(negedge clk) begin
    if (rst_n) begin
      bit          st, rdy;
      logic [63:0] e;
      st  = m_stall();
      rdy = !st && (!m_valid || ex_ready);
      check("id_ready", id_ready, rdy);
      check("ex_valid", ex_valid, m_valid);
      check("stall_cnt", stall_cnt, m_cnt);
      check("small_stall_cnt", s_stall_cnt, (m_cnt > 3) ? 3 : m_cnt);
      if (ex_valid && (ex_ready || flush)) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard: operands presented with none expected at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (ex_ready) begin
            check("alu_src1", alu_src1, e[63:32]);
            check("alu_src2", alu_src2, e[31:0]);
          end
        end
      end
      if (id_valid && rdy && !flush) exp_q.push_back(m_ops());
      if (flush)                m_valid = 0;
      else if (id_valid && rdy) m_valid = 1;
      else if (ex_ready)        m_valid = 0;
      if (st && m_cnt < 65535) m_cnt++;
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; id_valid = 0; src_sel = 0; rs1_addr = 0; rs2_addr = 0;
    reg1_rdata = 0; reg2_rdata = 0; imm = 0; curr_pc = 0;
    exm_wr_en = 0; exm_rd = 0; exm_alu_res = 0; exm_access = 0; exm_sign_ext = 0;
    mem_rdata = 0; mem_rvalid = 0; wb_wr_en = 0; wb_rd = 0; wb_data = 0; ex_ready = 1;
  endtask

  task automatic reg_op(input logic [1:0] sel, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] d1, input logic [31:0] d2);
    id_valid = 1; src_sel = sel; rs1_addr = r1; rs2_addr = r2;
    reg1_rdata = d1; reg2_rdata = d2;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ex_valid"}, ex_valid, 0);
    check({tag, "_src1"}, alu_src1, 0);
    check({tag, "_src2"}, alu_src2, 0);
    check({tag, "_stall_cnt"}, stall_cnt, 0);
    check({tag, "_small_ex_valid"}, s_ex_valid, 0);
    check({tag, "_small_stall_cnt"}, s_stall_cnt, 0);
  endtask

  initial begin
    rst_n = 0;
    idle();
    cyc();
    check_zero_outputs("reset");
    cyc();
    rst_n = 1;
    cyc();

    // REG mode, no forwarding
    reg_op(2'b00, 5'd1, 5'd2, 32'h11, 32'h22);
    cyc();
    id_valid = 0;
    check("reg_ex_valid", ex_valid, 1);
    check("reg_src1", alu_src1, 32'h11);
    check("reg_src2", alu_src2, 32'h22);

    // EX/MEM beats MEM/WB; x0 is never forwarded
    reg_op(2'b01, 5'd5, 5'd0, 32'h99, 32'h0);
    imm = 32'h33;
    exm_wr_en = 1; exm_rd = 5; exm_alu_res = 32'hA;
    wb_wr_en = 1; wb_rd = 5; wb_data = 32'hB;
    cyc();
    check("dbl_src1", alu_src1, 32'hA);
    check("dbl_src2", alu_src2, 32'h33);
    rs1_addr = 0; reg1_rdata = 32'h77; exm_rd = 0; wb_rd = 0;
    cyc();
    check("x0_src1", alu_src1, 32'h77);
    idle();
    cyc();

    // load-use wait: signed half from upper lane
    reg_op(2'b01, 5'd3, 5'd0, 32'h0, 32'h0);
    imm = 32'h55;
    exm_wr_en = 1; exm_rd = 3; exm_access = 2'b10; exm_sign_ext = 1;
    exm_alu_res = 32'h0000_0102; mem_rdata = 32'h8001_0000; mem_rvalid = 0;
    repeat (3) cyc();
    check("lu_stall_cnt", stall_cnt, 3);
    check("lu_id_ready", id_ready, 0);
    mem_rvalid = 1;
    #1;
    check("lu_id_ready_rel", id_ready, 1);
    cyc();
    check("lu_ex_valid", ex_valid, 1);
    check("lu_src1", alu_src1, 32'hFFFF_8001);
    check("lu_src2", alu_src2, 32'h55);
    idle();
    cyc();

    // backpressure
    ex_ready = 0;
    reg_op(2'b00, 5'd1, 5'd2, 32'hA1, 32'hA2);
    cyc();
    reg_op(2'b00, 5'd1, 5'd2, 32'hB1, 32'hB2);
    for (int i = 0; i < 4; i++) begin
      check("bp_id_ready", id_ready, 0);
      check("bp_src1", alu_src1, 32'hA1);
      check("bp_src2", alu_src2, 32'hA2);
      check("bp_ex_valid", ex_valid, 1);
      cyc();
    end
    ex_ready = 1;
    #1;
    check("bp_id_ready_rel", id_ready, 1);
    cyc();
    id_valid = 0;
    check("bp_next_src1", alu_src1, 32'hB1);
    check("bp_next_src2", alu_src2, 32'hB2);
    cyc();

    // flush with capture, then flush during hold
    reg_op(2'b11, 5'd0, 5'd0, 32'h0, 32'h0);
    imm = 32'hC0; curr_pc = 32'h100; flush = 1;
    cyc();
    check("flush_cap_ex_valid", ex_valid, 0);
    flush = 0; ex_ready = 0;
    cyc();
    id_valid = 0;
    check("hold_ex_valid", ex_valid, 1);
    check("hold_src1", alu_src1, 32'hC0);
    flush = 1;
    cyc();
    check("flush_hold_ex_valid", ex_valid, 0);
    idle();
    cyc();

    // saturation on the narrow counter, then reset mid-stall
    reg_op(2'b00, 5'd1, 5'd3, 32'h0, 32'h0);
    exm_wr_en = 1; exm_rd = 3; exm_access = 2'b01; mem_rvalid = 0;
    repeat (5) cyc();
    check("sat_small_cnt", s_stall_cnt, 3);
    check("sat_main_cnt", stall_cnt, 8);
    rst_n = 0;
    #1;
    check_zero_outputs("mid_stall_reset");
    check("reset_id_ready", id_ready, 0);
    idle();
    cyc();
    rst_n = 1;
    cyc();
    check("post_reset_ex_valid", ex_valid, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      src_sel      = 2'($urandom_range(0, 3));
      rs1_addr     = 5'($urandom_range(0, 3));
      rs2_addr     = 5'($urandom_range(0, 3));
      reg1_rdata   = $urandom;
      reg2_rdata   = $urandom;
      imm          = $urandom;
      curr_pc      = $urandom;
      exm_wr_en    = 1'($urandom_range(0, 1));
      exm_rd       = 5'($urandom_range(0, 3));
      exm_alu_res  = $urandom;
      exm_access   = 2'($urandom_range(0, 3));
      exm_sign_ext = 1'($urandom_range(0, 1));
      mem_rdata    = $urandom;
      mem_rvalid   = ($urandom_range(0, 2) != 0);
      wb_wr_en     = 1'($urandom_range(0, 1));
      wb_rd        = 5'($urandom_range(0, 3));
      wb_data      = $urandom;
      ex_ready     = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      cyc();
    end

    idle();
    repeat (3) cyc();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
